// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the serial multiple-of detector.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 1;
  localparam int MIN_DIV   = 2;

  // Ceiling log2; 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Register width able to hold 0..v-1, never narrower than one bit.
  function automatic int width_of(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/mult_serial_mod_residue.sv
// Running residue modulo D of an MSB-first bit stream.
module mod_residue
  import mult_pkg::*;
#(
  parameter int D = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic zero
);

  localparam int RW = width_of(D);
  localparam logic [RW:0]   D_EXT = (RW + 1)'(D);
  // The subtract result is below D, so only the low RW bits matter.
  localparam logic [RW-1:0] D_LO  = RW'(D);

  logic [RW-1:0] r_reg;
  logic [RW-1:0] r_next;
  logic [RW:0]   sum;

  always_comb begin
    sum    = {r_reg, bit_in};
    r_next = (sum >= D_EXT) ? (sum[RW-1:0] - D_LO) : sum[RW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg <= '0;
    end else if (clr) begin
      r_reg <= '0;
    end else if (en) begin
      r_reg <= r_next;
    end
  end

  assign zero = (r_reg == '0);

endmodule

// File: rtl/mult_serial.sv
// Serial detector: flags whether a WIDTH-bit operand is a multiple of DIV1 / DIV2.
module mult_serial
  import mult_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DIV1         = 3,
  parameter int DIV2         = 2,
  parameter int ZERO_IS_MULT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             done,
  output logic             led1,
  output logic             led2
);

  localparam int            CW       = width_of(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic          ZERO_OK  = (ZERO_IS_MULT != 0);

  generate
    if (WIDTH < MIN_WIDTH) begin : g_bad_width
      $error("mult_serial: WIDTH must be >= 1");
    end
    if (DIV1 < MIN_DIV) begin : g_bad_div1
      $error("mult_serial: DIV1 must be >= 2");
    end
    if (DIV2 < MIN_DIV) begin : g_bad_div2
      $error("mult_serial: DIV2 must be >= 2");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  shift_reg;
  logic [CW-1:0]     cnt_reg;
  logic              nonzero_reg;
  logic              led1_reg, led2_reg;
  logic              load, step;
  logic              zero1, zero2;
  logic              flag1, flag2;

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_reg == '0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      nonzero_reg <= 1'b0;
      led1_reg    <= 1'b0;
      led2_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        shift_reg   <= in_data;
        cnt_reg     <= CNT_INIT;
        nonzero_reg <= 1'b0;
      end else if (step) begin
        shift_reg   <= shift_reg << 1;
        nonzero_reg <= nonzero_reg | shift_reg[WIDTH-1];
        if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
      end
      if (state_reg == DONE) begin
        led1_reg <= flag1;
        led2_reg <= flag2;
      end
    end
  end

  mod_residue #(.D(DIV1)) u_res1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (load),
    .en     (step),
    .bit_in (shift_reg[WIDTH-1]),
    .zero   (zero1)
  );

  mod_residue #(.D(DIV2)) u_res2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (load),
    .en     (step),
    .bit_in (shift_reg[WIDTH-1]),
    .zero   (zero2)
  );

  assign flag1 = zero1 && (nonzero_reg || ZERO_OK);
  assign flag2 = zero2 && (nonzero_reg || ZERO_OK);

  // In DONE the fresh flags go straight out; afterwards the held copies do.
  assign in_ready = (state_reg == IDLE);
  assign done     = (state_reg == DONE);
  assign led1     = done ? flag1 : led1_reg;
  assign led2     = done ? flag2 : led2_reg;

endmodule

// File: tb/tb_mult_serial.sv
// Self-checking bench: four mult_serial configurations against a modulo reference model.
module tb_mult_serial;

  logic        clk;
  logic [3:0]  rstn;
  logic [3:0]  vld;
  logic [3:0]  rdy, dn, l1, l2;
  logic [7:0]  d0, d1;
  logic [3:0]  d2;
  logic [11:0] d3;
  int          tests_run;
  int          tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults; 1: zero counts as multiple; 2: 4-bit; 3: 12-bit with 7/5.
  mult_serial #(.WIDTH(8), .DIV1(3), .DIV2(2), .ZERO_IS_MULT(0)) u_def (
    .clk(clk), .rst_n(rstn[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .in_data(d0), .done(dn[0]), .led1(l1[0]), .led2(l2[0]));
  mult_serial #(.WIDTH(8), .DIV1(3), .DIV2(2), .ZERO_IS_MULT(1)) u_z1 (
    .clk(clk), .rst_n(rstn[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .in_data(d1), .done(dn[1]), .led1(l1[1]), .led2(l2[1]));
  mult_serial #(.WIDTH(4), .DIV1(3), .DIV2(2), .ZERO_IS_MULT(0)) u_w4 (
    .clk(clk), .rst_n(rstn[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .in_data(d2), .done(dn[2]), .led1(l1[2]), .led2(l2[2]));
  mult_serial #(.WIDTH(12), .DIV1(7), .DIV2(5), .ZERO_IS_MULT(0)) u_w12 (
    .clk(clk), .rst_n(rstn[3]), .in_valid(vld[3]), .in_ready(rdy[3]),
    .in_data(d3), .done(dn[3]), .led1(l1[3]), .led2(l2[3]));

  function automatic logic ref_flag(input int v, input int d, input int z);
    return ((v % d) == 0) && ((v != 0) || (z != 0));
  endfunction

  task automatic set_data(input int idx, input logic [11:0] v);
    case (idx)
      0:       d0 = v[7:0];
      1:       d1 = v[7:0];
      2:       d2 = v[3:0];
      default: d3 = v;
    endcase
  endtask

  // Offer one operand, scramble in_data after the accept edge, wait for done.
  // lat counts cycles from the accept cycle to the done cycle (-1: never accepted).
  task automatic op(input int idx, input logic [11:0] v, output int lat,
                    output logic o1, output logic o2, output logic stable);
    int   w;
    logic p1, p2;
    @(negedge clk);
    set_data(idx, v);
    vld[idx] = 1'b1;
    w = 0;
    while (!rdy[idx] && w < 50) begin
      @(negedge clk);
      w++;
    end
    p1 = l1[idx];
    p2 = l2[idx];
    stable = 1'b1;
    o1 = 1'bx;
    o2 = 1'bx;
    if (!rdy[idx]) begin
      vld[idx] = 1'b0;
      lat = -1;
    end else begin
      @(negedge clk);
      vld[idx] = 1'b0;
      set_data(idx, ~v);
      lat = 1;
      while (!dn[idx] && lat < 40) begin
        if (l1[idx] !== p1 || l2[idx] !== p2) stable = 1'b0;
        @(negedge clk);
        lat++;
      end
      o1 = l1[idx];
      o2 = l2[idx];
    end
  endtask

  task automatic test_reset();
    rstn = 4'h0;
    vld  = 4'h0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (rdy[i] !== 1'b1 || dn[i] !== 1'b0 || l1[i] !== 1'b0 || l2[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset inst%0d: ready/done/led1/led2 = %b%b%b%b, want 1000",
                 i, rdy[i], dn[i], l1[i], l2[i]);
      end
    end
    rstn = 4'hF;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat; logic o1, o2, st;
    op(0, 12'h000, lat, o1, o2, st);
    tests_run++;
    if (o1 !== 1'b0 || o2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_z0: led1/led2 = %b%b, want 00", o1, o2);
    end
    op(1, 12'h000, lat, o1, o2, st);
    tests_run++;
    if (o1 !== 1'b1 || o2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_z1: led1/led2 = %b%b, want 11", o1, o2);
    end
  endtask

  task automatic test_basic();
    int lat; logic o1, o2, st;
    op(0, 12'h00C, lat, o1, o2, st);
    tests_run++;
    if (lat !== 9) begin
      tests_failed++;
      $display("FAIL basic_latency: %0d cycles, want 9", lat);
    end
    tests_run++;
    if (o1 !== 1'b1 || o2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_0x0C: led1/led2 = %b%b, want 11", o1, o2);
    end
  endtask

  task automatic test_mid_reset();
    int   w;
    logic saw_done;
    int   lat; logic o1, o2, st;
    @(negedge clk);
    d0 = 8'h0C;
    vld[0] = 1'b1;
    w = 0;
    while (!rdy[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    rstn[0] = 1'b0;
    #1;
    tests_run++;
    if (rdy[0] !== 1'b1 || dn[0] !== 1'b0 || l1[0] !== 1'b0 || l2[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: ready/done/led1/led2 = %b%b%b%b, want 1000",
               rdy[0], dn[0], l1[0], l2[0]);
    end
    @(negedge clk);
    rstn[0] = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dn[0]) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_no_done: done seen = %b, want 0", saw_done);
    end
    op(0, 12'h006, lat, o1, o2, st);
    tests_run++;
    if (o1 !== 1'b1 || o2 !== 1'b1 || lat !== 9) begin
      tests_failed++;
      $display("FAIL after_reset_0x06: led1/led2 = %b%b lat %0d, want 11 lat 9", o1, o2, lat);
    end
  endtask

  task automatic test_back_to_back();
    int   w, acc2, dn1, dn2;
    logic f1, f2, s1, s2;
    acc2 = -1; dn1 = -1; dn2 = -1;
    f1 = 1'bx; f2 = 1'bx; s1 = 1'bx; s2 = 1'bx;
    @(negedge clk);
    d0 = 8'hFF;
    vld[0] = 1'b1;
    w = 0;
    while (!rdy[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    for (int k = 1; k <= 40 && dn2 < 0; k++) begin
      @(negedge clk);
      if (k == 1) d0 = 8'hFE;
      if (dn[0]) begin
        if (dn1 < 0) begin
          dn1 = k; f1 = l1[0]; f2 = l2[0];
        end else begin
          dn2 = k; s1 = l1[0]; s2 = l2[0];
        end
      end
      if (rdy[0] && acc2 < 0) acc2 = k;
    end
    vld[0] = 1'b0;
    tests_run++;
    if (dn1 !== 9 || f1 !== 1'b1 || f2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first_0xFF: done@%0d led1/led2 = %b%b, want done@9 10", dn1, f1, f2);
    end
    tests_run++;
    if (acc2 !== 10) begin
      tests_failed++;
      $display("FAIL b2b_second_accept: cycle %0d, want 10", acc2);
    end
    tests_run++;
    if (dn2 !== 19 || s1 !== 1'b0 || s2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second_0xFE: done@%0d led1/led2 = %b%b, want done@19 01", dn2, s1, s2);
    end
  endtask

  task automatic test_sweep_w4();
    int lat; logic o1, o2, st;
    logic e1, e2;
    for (int v = 0; v < 16; v++) begin
      op(2, 12'(v), lat, o1, o2, st);
      e1 = ref_flag(v, 3, 0);
      e2 = ref_flag(v, 2, 0);
      tests_run++;
      if (o1 !== e1 || o2 !== e2 || lat !== 5) begin
        tests_failed++;
        $display("FAIL sweep_w4 v=%0d: led1/led2 = %b%b lat %0d, want %b%b lat 5",
                 v, o1, o2, lat, e1, e2);
      end
      tests_run++;
      if (st !== 1'b1) begin
        tests_failed++;
        $display("FAIL sweep_w4_hold v=%0d: leds stable = %b, want 1", v, st);
      end
    end
  endtask

  task automatic test_random_w12();
    int   q[$];
    int   pushed, got, cyc, last_done, exp_v;
    logic pend, e1, e2;
    pushed = 0; got = 0; cyc = 0; last_done = -1; pend = 1'b0;
    @(negedge clk);
    d3 = 12'($urandom_range(0, 4095));
    vld[3] = 1'b1;
    while (got < 1000 && cyc < 20000) begin
      if (dn[3]) begin
        exp_v = (q.size() > 0) ? q.pop_front() : -1;
        e1 = ref_flag(exp_v, 7, 0);
        e2 = ref_flag(exp_v, 5, 0);
        tests_run++;
        if (exp_v < 0 || l1[3] !== e1 || l2[3] !== e2) begin
          tests_failed++;
          $display("FAIL rand_w12 v=%0d: led1/led2 = %b%b, want %b%b", exp_v, l1[3], l2[3], e1, e2);
        end
        if (last_done >= 0) begin
          tests_run++;
          if (cyc - last_done < 14) begin
            tests_failed++;
            $display("FAIL rand_w12_spacing: %0d cycles between done, want >= 14", cyc - last_done);
          end
        end
        last_done = cyc;
        got++;
      end
      if (pend) begin
        d3 = 12'($urandom_range(0, 4095));
        if (pushed >= 1000) vld[3] = 1'b0;
        pend = 1'b0;
      end
      if (rdy[3] && vld[3]) begin
        q.push_back(int'(d3));
        pushed++;
        pend = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    vld[3] = 1'b0;
    tests_run++;
    if (got !== 1000) begin
      tests_failed++;
      $display("FAIL rand_w12_count: %0d results, want 1000", got);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_zero();
    test_basic();
    test_mid_reset();
    test_back_to_back();
    test_sweep_w4();
    test_random_w12();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
